wordle_guess_scorer: RTL

- Scores a completed 5-letter guess against the secret word and produces one colour code per letter (green / yellow / grey) plus a win flag.
- Sits between the game state machine, which produces the guess letters and the random word, and the VGA tile renderer, which consumes the per-letter colours.
- Multi-cycle. Duplicate letters follow standard Wordle rules: greens are resolved first, then yellows are assigned left to right against answer letters not yet consumed.

---
 rtl/wordle_guess_scorer_pkg.sv | 45 ++++
 rtl/wordle_guess_scorer_if.sv | 34 +++
 rtl/wordle_guess_scorer_letter_find.sv | 39 +++
 rtl/wordle_guess_scorer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wordle_guess_scorer_pkg.sv
// -----------------------------------------------------------------------------
// wordle_pkg
// Shared definitions for the Wordle guess scorer and the VGA tile renderer:
// word geometry, per-letter colour codes, packed word/colour types and the
// scorer state encoding.
//
// Packing note: a word_t / colours_t element index k is the bit significance
// of the letter inside the 40-bit bus. k = WORD_LEN-1 is the FIRST (leftmost)
// letter, k = 0 the last one, so bus[39:32] == word[4] and result[9:8] == col[4].
// -----------------------------------------------------------------------------
package wordle_pkg;

    localparam int WORD_LEN  = 5;                 // only 5 is supported
    localparam int CHAR_W    = 8;                 // ASCII code per letter
    localparam int WORD_BITS = WORD_LEN * CHAR_W;
    localparam int RESULT_W  = 2 * WORD_LEN;

    typedef logic [1:0] colour_t;

    localparam colour_t COL_GREY   = 2'b00;
    localparam colour_t COL_YELLOW = 2'b01;
    localparam colour_t COL_GREEN  = 2'b10;

    typedef logic [WORD_LEN-1:0][CHAR_W-1:0] word_t;
    typedef logic [WORD_LEN-1:0][1:0]        colours_t;

    localparam colours_t ALL_GREEN = {WORD_LEN{COL_GREEN}};
    localparam colours_t ALL_GREY  = {WORD_LEN{COL_GREY}};

    // Element index of the leftmost letter (scoring starts here).
    localparam logic [2:0] POS_FIRST = 3'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_FINISH = 2'b11
    } scorer_state_t;

    // True when every letter of a scored word is green.
    function automatic logic all_green(input colours_t cols);
        return (cols == ALL_GREEN);
    endfunction

endpackage

// File: rtl/wordle_guess_scorer_if.sv
// -----------------------------------------------------------------------------
// wordle_guess_scorer_if
// Request/result bundle between the game state machine (master) and the
// guess scorer (slave).
//   start  : master -> slave, one-cycle scoring request
//   guess  : master -> slave, 40-bit guess, [39:32] first letter
//   answer : master -> slave, 40-bit secret word, same packing
//   busy   : slave -> master, scoring in progress
//   done   : slave -> master, one-cycle pulse, result/win updated
//   result : slave -> master, 2 bits per letter, [9:8] first letter
//   win    : slave -> master, all letters green in last scored guess
// -----------------------------------------------------------------------------
interface wordle_guess_scorer_if;
    import wordle_pkg::*;

    logic                 start;
    logic [WORD_BITS-1:0] guess;
    logic [WORD_BITS-1:0] answer;
    logic                 busy;
    logic                 done;
    logic [RESULT_W-1:0]  result;
    logic                 win;

    modport master (
        output start, guess, answer,
        input  busy, done, result, win
    );

    modport slave (
        input  start, guess, answer,
        output busy, done, result, win
    );

endinterface

// File: rtl/wordle_guess_scorer_letter_find.sv
// -----------------------------------------------------------------------------
// wordle_letter_find
// Combinational search for the leftmost answer letter equal to 'letter' that
// has not yet been consumed.
//   letter : letter being looked up (raw 8-bit code)
//   answer : secret word, word_t packing (element WORD_LEN-1 = first letter)
//   used   : consumed mask, same element order as answer
//   found  : a free matching letter exists
//   j      : one-hot position of that letter (zero when not found)
// -----------------------------------------------------------------------------
module wordle_letter_find
    import wordle_pkg::*;
(
    input  logic [CHAR_W-1:0]   letter,
    input  word_t               answer,
    input  logic [WORD_LEN-1:0] used,
    output logic                found,
    output logic [WORD_LEN-1:0] j
);

    // Scan from the last letter upward; a later hit overwrites an earlier one,
    // so the surviving match is the one with the highest element index, i.e.
    // the leftmost letter of the word.
    always_comb begin
        found = 1'b0;
        j     = {WORD_LEN{1'b0}};
        for (int k = 0; k < WORD_LEN; k++) begin
            if (!used[k] && (answer[k] == letter)) begin
                found = 1'b1;
                j     = {{(WORD_LEN-1){1'b0}}, 1'b1} << k;
            end else begin
                // keep whichever match was recorded so far
                found = found;
                j     = j;
            end
        end
    end

endmodule

// File: rtl/wordle_guess_scorer.sv
// -----------------------------------------------------------------------------
// wordle_guess_scorer
// Scores a latched 5-letter guess against a latched answer using Wordle rules:
// greens are resolved in one cycle, then yellows are assigned one letter per
// cycle from left to right against answer letters not yet consumed.
// Timeline from the start edge E0: GREEN at E1, YELLOW at E2..E6, FINISH at
// E7, so done is visible 7 edges after start was sampled.
//   Clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : request/result bundle (slave side), see wordle_guess_scorer_if
// result/win are only written in FINISH, so they are stable while busy.
// -----------------------------------------------------------------------------
module wordle_guess_scorer
    import wordle_pkg::*;
(
    input  logic                  Clk,
    input  logic                  reset,
    wordle_guess_scorer_if.slave  bus
);

    scorer_state_t        state_r;
    word_t                guess_r;
    word_t                answer_r;
    logic [WORD_LEN-1:0]  used_r;
    colours_t             work_r;
    logic [2:0]           pos_r;      // element index of the letter being scored
    logic                 busy_r;
    logic                 done_r;
    colours_t             result_r;
    logic                 win_r;

    logic [CHAR_W-1:0]    cur_letter_s;
    logic                 found_s;
    logic [WORD_LEN-1:0]  j_s;

    // Guess letter currently under yellow evaluation.
    always_comb begin
        cur_letter_s = {CHAR_W{1'b0}};
        if (pos_r <= POS_FIRST) begin
            cur_letter_s = guess_r[pos_r];
        end else begin
            cur_letter_s = {CHAR_W{1'b0}};
        end
    end

    wordle_letter_find u_letter_find (
        .letter (cur_letter_s),
        .answer (answer_r),
        .used   (used_r),
        .found  (found_s),
        .j      (j_s)
    );

    // Scoring sequencer: latch, green pass, per-letter yellow pass, publish.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            guess_r  <= {WORD_BITS{1'b0}};
            answer_r <= {WORD_BITS{1'b0}};
            used_r   <= {WORD_LEN{1'b0}};
            work_r   <= ALL_GREY;
            pos_r    <= 3'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ALL_GREY;
            win_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        guess_r  <= bus.guess;
                        answer_r <= bus.answer;
                        used_r   <= {WORD_LEN{1'b0}};
                        work_r   <= ALL_GREY;
                        busy_r   <= 1'b1;
                        state_r  <= ST_GREEN;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end

                ST_GREEN: begin
                    for (int k = 0; k < WORD_LEN; k++) begin
                        if (guess_r[k] == answer_r[k]) begin
                            work_r[k] <= COL_GREEN;
                            used_r[k] <= 1'b1;
                        end
                    end
                    pos_r   <= POS_FIRST;
                    state_r <= ST_YELLOW;
                end

                ST_YELLOW: begin
                    // Green letters are skipped but still spend their cycle.
                    if ((work_r[pos_r] != COL_GREEN) && found_s) begin
                        work_r[pos_r] <= COL_YELLOW;
                        used_r        <= used_r | j_s;
                    end
                    if (pos_r == 3'd0) begin
                        state_r <= ST_FINISH;
                    end else begin
                        pos_r   <= pos_r - 3'd1;
                    end
                end

                ST_FINISH: begin
                    result_r <= work_r;
                    win_r    <= all_green(work_r);
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end

                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.win    = win_r;

endmodule
